// File: rtl/pacman_pkg.sv
// Shared Pac-Man board definitions: tile codes, board geometry and tracker state.
package pacman_pkg;

  localparam int unsigned BOARD_ROWS = 36;
  localparam int unsigned BOARD_COLS = 28;
  localparam int unsigned SCAN_IDX_W = 10;
  localparam int unsigned ROW_W      = 6;
  localparam int unsigned COL_W      = 5;
  localparam int unsigned DOTS_W     = 10;
  localparam int unsigned SCORE_W    = 6;

  localparam logic [7:0] TILE_DOT   = 8'h01;
  localparam logic [7:0] TILE_POWER = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_PLAY  = 2'd2,
    S_CLEAR = 2'd3
  } tracker_state_e;

  function automatic logic is_pellet(input logic [7:0] code);
    return (code == TILE_DOT) || (code == TILE_POWER);
  endfunction

endpackage

// File: rtl/pellet_scan_counter.sv
// Board scan index with nested row/col counters so tile addressing needs no multiply.
module pellet_scan_counter
  import pacman_pkg::*;
#(
  parameter int unsigned ROWS = BOARD_ROWS,
  parameter int unsigned COLS = BOARD_COLS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_step,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last_c
);

  logic [SCAN_IDX_W-1:0] idx_q;

  assign o_last_c = (idx_q == SCAN_IDX_W'(ROWS * COLS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      idx_q <= '0;
      o_row <= '0;
      o_col <= '0;
    end else if (i_step) begin
      if (o_last_c) begin
        idx_q <= '0;
        o_row <= '0;
        o_col <= '0;
      end else begin
        idx_q <= idx_q + SCAN_IDX_W'(1);
        if (o_col == COL_W'(COLS - 1)) begin
          o_col <= '0;
          o_row <= o_row + ROW_W'(1);
        end else begin
          o_col <= o_col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pellet_tracker.sv
// Owns per-level pellet state: scans the board after reload, then services Pac-Man eats.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int unsigned ROWS        = BOARD_ROWS,
  parameter int unsigned COLS        = BOARD_COLS,
  parameter int unsigned DOT_SCORE   = 10,
  parameter int unsigned POWER_SCORE = 50
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_reload_done,
  input  logic [ROWS-1:0][COLS-1:0][7:0]   i_board,
  input  logic                             i_pac_valid,
  input  logic [ROW_W-1:0]                 i_pac_row,
  input  logic [COL_W-1:0]                 i_pac_col,
  output logic                             o_busy,
  output logic [DOTS_W-1:0]                o_dots_left,
  output logic                             o_eat_dot,
  output logic                             o_eat_power,
  output logic [SCORE_W-1:0]               o_score_add,
  output logic                             o_level_clear,
  output logic [ROWS-1:0][COLS-1:0]        o_eaten
);

  tracker_state_e state_q, state_d;

  logic [ROW_W-1:0]  scan_row;
  logic [COL_W-1:0]  scan_col;
  logic              scan_last_c;
  logic              scan_hit_c;
  logic [DOTS_W-1:0] scan_total_c;
  logic              pac_in_range_c;
  logic [7:0]        pac_tile_c;
  logic              eat_ok_c;
  logic              eat_last_c;

  logic                      busy_d;
  logic [DOTS_W-1:0]         dots_d;
  logic                      eat_dot_d;
  logic                      eat_power_d;
  logic [SCORE_W-1:0]        score_d;
  logic                      level_clear_d;
  logic [ROWS-1:0][COLS-1:0] eaten_d;

  pellet_scan_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_scan (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (i_reload_done),
    .i_step   (state_q == S_SCAN),
    .o_row    (scan_row),
    .o_col    (scan_col),
    .o_last_c (scan_last_c)
  );

  // Scan and eat qualification; reload always pre-empts a same-cycle eat.
  always_comb begin
    scan_hit_c     = is_pellet(i_board[scan_row][scan_col]);
    scan_total_c   = o_dots_left + DOTS_W'(scan_hit_c);
    pac_in_range_c = (i_pac_row < ROW_W'(ROWS)) && (i_pac_col < COL_W'(COLS));
    pac_tile_c     = i_board[i_pac_row][i_pac_col];
    eat_ok_c       = (state_q == S_PLAY) && i_pac_valid && !i_reload_done && pac_in_range_c
                     && is_pellet(pac_tile_c) && !o_eaten[i_pac_row][i_pac_col];
    eat_last_c     = eat_ok_c && (o_dots_left == DOTS_W'(1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_reload_done) begin
      state_d = S_SCAN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_SCAN:  if (scan_last_c) state_d = (scan_total_c == '0) ? S_CLEAR : S_PLAY;
        S_PLAY:  if (eat_last_c) state_d = S_CLEAR;
        S_CLEAR: state_d = S_CLEAR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d        = (state_d == S_SCAN);
    dots_d        = o_dots_left;
    eat_dot_d     = 1'b0;
    eat_power_d   = 1'b0;
    score_d       = '0;
    level_clear_d = 1'b0;
    eaten_d       = o_eaten;
    if (i_reload_done) begin
      dots_d  = '0;
      eaten_d = '0;
    end else begin
      case (state_q)
        S_SCAN: begin
          dots_d = scan_total_c;
          if (scan_last_c && (scan_total_c == '0)) level_clear_d = 1'b1;
        end
        S_PLAY: begin
          if (eat_ok_c) begin
            eaten_d[i_pac_row][i_pac_col] = 1'b1;
            dots_d        = o_dots_left - DOTS_W'(1);
            level_clear_d = eat_last_c;
            if (pac_tile_c == TILE_POWER) begin
              eat_power_d = 1'b1;
              score_d     = SCORE_W'(POWER_SCORE);
            end else begin
              eat_dot_d = 1'b1;
              score_d   = SCORE_W'(DOT_SCORE);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy        <= 1'b0;
      o_dots_left   <= '0;
      o_eat_dot     <= 1'b0;
      o_eat_power   <= 1'b0;
      o_score_add   <= '0;
      o_level_clear <= 1'b0;
      o_eaten       <= '0;
    end else begin
      o_busy        <= busy_d;
      o_dots_left   <= dots_d;
      o_eat_dot     <= eat_dot_d;
      o_eat_power   <= eat_power_d;
      o_score_add   <= score_d;
      o_level_clear <= level_clear_d;
      o_eaten       <= eaten_d;
    end
  end

endmodule

// File: tb/tb_pellet_tracker.sv
// Bench for pellet_tracker: directed board scenarios plus random eats against a pellet-set model.
module tb_pellet_tracker;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    reload = 1'b0;
  logic [35:0][27:0][7:0]  board = '0;
  logic                    pac_valid = 1'b0;
  logic [5:0]              pac_row = '0;
  logic [4:0]              pac_col = '0;
  logic                    busy;
  logic [9:0]              dots_left;
  logic                    eat_dot;
  logic                    eat_power;
  logic [5:0]              score_add;
  logic                    level_clear;
  logic [35:0][27:0]       eaten;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: which pellets are gone, how many remain, whether eats count.
  bit [35:0][27:0] m_eaten;
  int              m_left;
  bit              m_live;

  pellet_tracker dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_reload_done (reload),
    .i_board       (board),
    .i_pac_valid   (pac_valid),
    .i_pac_row     (pac_row),
    .i_pac_col     (pac_col),
    .o_busy        (busy),
    .o_dots_left   (dots_left),
    .o_eat_dot     (eat_dot),
    .o_eat_power   (eat_power),
    .o_score_add   (score_add),
    .o_level_clear (level_clear),
    .o_eaten       (eaten)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic bit pellet(input logic [7:0] code);
    return (code == 8'h01) || (code == 8'h02);
  endfunction

  function automatic logic [7:0] rand_blank();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (pellet(v)) v = 8'h00;
    return v;
  endfunction

  function automatic int count_pellets();
    int n = 0;
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++)
        if (pellet(board[r][c])) n++;
    return n;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dots"}, dots_left, 0);
    check({tag, "_dot"}, eat_dot, 0);
    check({tag, "_pow"}, eat_power, 0);
    check({tag, "_score"}, score_add, 0);
    check({tag, "_clr"}, level_clear, 0);
    check({tag, "_mask"}, $countones(eaten), 0);
  endtask

  // Pulse reload and follow the scan; optionally poke an eat or a restart mid-scan.
  task automatic scan(input int eat_k, input int restart_k);
    int  cnt;
    int  guard;
    bit  hit;
    bit  restarted;
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("scan_busy0", busy, 1);
    check("scan_dots0", dots_left, 0);
    check("scan_mask0", $countones(eaten), 0);
    cnt = 0;
    guard = 0;
    while (busy && guard < 5000) begin
      cnt++;
      guard++;
      hit       = (cnt == eat_k) || (cnt == restart_k);
      restarted = (cnt == restart_k);
      if (hit) begin
        pac_valid = 1'b1;
        pac_row   = 6'd1;
        pac_col   = 5'd1;
      end
      if (restarted) reload = 1'b1;
      @(negedge clk);
      reload    = 1'b0;
      pac_valid = 1'b0;
      if (hit) begin
        check("scan_eat_dot", eat_dot, 0);
        check("scan_eat_pow", eat_power, 0);
        check("scan_eat_score", score_add, 0);
      end
      if (restarted) begin
        check("restart_busy", busy, 1);
        check("restart_dots", dots_left, 0);
        check("restart_mask", $countones(eaten), 0);
        cnt = 0;
        restart_k = -1;
      end
    end
    check("busy_cycles", cnt, 1008);
    m_eaten = '0;
    m_left  = count_pellets();
    m_live  = (m_left > 0);
    check("scan_dots", dots_left, m_left);
    check("scan_clr", level_clear, (m_left == 0) ? 1 : 0);
    if (m_left == 0) begin
      @(negedge clk);
      check("scan_clr_once", level_clear, 0);
    end
  endtask

  // Consecutive calls keep i_pac_valid high across cycles, exercising back-to-back eats.
  task automatic eat(input int r, input int c);
    bit         q;
    bit         pw;
    bit         inr;
    logic [7:0] code;
    pac_row   = 6'(r);
    pac_col   = 5'(c);
    pac_valid = 1'b1;
    @(negedge clk);
    pac_valid = 1'b0;
    inr = (r < 36) && (c < 28);
    q   = 1'b0;
    pw  = 1'b0;
    if (inr && m_live) begin
      code = board[r][c];
      if (pellet(code) && !m_eaten[r][c]) begin
        q  = 1'b1;
        pw = (code == 8'h02);
      end
    end
    if (q) begin
      m_eaten[r][c] = 1'b1;
      m_left--;
    end
    check("eat_dot", eat_dot, (q && !pw) ? 1 : 0);
    check("eat_pow", eat_power, (q && pw) ? 1 : 0);
    check("eat_score", score_add, q ? (pw ? 50 : 10) : 0);
    check("eat_dots_left", dots_left, m_left);
    check("eat_clr", level_clear, (q && m_left == 0) ? 1 : 0);
    if (inr) check("eat_bit", eaten[r][c], m_eaten[r][c]);
    if (q && m_left == 0) m_live = 1'b0;
  endtask

  task automatic load_small_board();
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++)
        board[r][c] = rand_blank();
    board[1][1] = 8'h01;
    board[1][2] = 8'h01;
    board[3][1] = 8'h02;
  endtask

  initial begin
    m_eaten = '0;
    m_left  = 0;
    m_live  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");
    eat(1, 1);

    // Directed three-pellet level through to clear
    load_small_board();
    scan(-1, -1);
    eat(1, 1);
    eat(1, 1);
    eat(36, 0);
    eat(0, 28);
    eat(0, 0);
    eat(3, 1);
    eat(1, 2);
    eat(1, 1);
    check("clear_mask", $countones(eaten), $countones(m_eaten));

    // Eat during scan, restart at index 500 with a coincident eat, then back-to-back eats
    scan(20, 501);
    eat(1, 1);
    eat(3, 1);
    eat(3, 1);
    eat(1, 2);

    // Random board with random eats, then sweep the remainder to force a clear
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++) begin
        int v;
        v = $urandom_range(0, 31);
        board[r][c] = (v == 0) ? 8'h01 : (v == 1) ? 8'h02 : rand_blank();
      end
    scan(-1, -1);
    for (int i = 0; i < 300; i++) eat($urandom_range(0, 37), $urandom_range(0, 29));
    check("rand_mask", $countones(eaten), $countones(m_eaten));
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++)
        if (m_live && pellet(board[r][c]) && !m_eaten[r][c]) eat(r, c);
    check("rand_live", m_live, 0);
    check("rand_mask_end", $countones(eaten), $countones(m_eaten));

    // Empty board clears immediately after the scan
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++)
        board[r][c] = rand_blank();
    scan(-1, -1);
    eat(1, 1);

    // Reset mid-play beats a coincident eat and returns to idle
    load_small_board();
    scan(-1, -1);
    eat(1, 1);
    pac_row   = 6'd1;
    pac_col   = 5'd2;
    pac_valid = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    pac_valid = 1'b0;
    rst       = 1'b0;
    check_reset_vals("midrst");
    m_eaten = '0;
    m_left  = 0;
    m_live  = 1'b0;
    eat(1, 2);
    eat(3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
